cordic_wave_sequencer: RTL and testbench

Control sequencer for the iterative CORDIC waveform datapath. It owns the phase accumulator and the active frequency/waveform configuration. On each sample tick it folds the phase into the first quadrant and runs one start/done handshake with the CORDIC core. It then applies quadrant sign/swap and emits an 8-bit offset-binary sample; triangle and sawtooth are derived directly from phase, with no CORDIC transaction.

---
 rtl/cordic_wave_sequencer.sv | 151 +++++++++++++++
 tb/tb_cordic_wave_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_wave_sequencer.sv
// Sample-rate sequencer for the iterative CORDIC waveform generator: phase accumulator,
// shadowed configuration, one start/done handshake per sine/cosine sample, and quadrant shaping.
module cordic_wave_sequencer #(
    parameter int PHASE_W = 16,
    parameter int FREQ_W  = 13,
    parameter int MAG_W   = 7,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 tick,
    input  logic                 cfg_load,
    input  logic [FREQ_W-1:0]    freq_word,
    input  logic [1:0]           wave_sel,
    output logic                 cordic_start,
    output logic [PHASE_W-3:0]   cordic_angle,
    input  logic                 cordic_done,
    input  logic [MAG_W-1:0]     cordic_sin,
    input  logic [MAG_W-1:0]     cordic_cos,
    output logic [7:0]           sample,
    output logic                 sample_valid,
    output logic                 busy,
    output logic                 overrun,
    output logic                 timeout_err
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, SHAPE, OUT} state_t;

    state_t               state;
    state_t               state_next;
    logic [PHASE_W-1:0]   phase;
    logic [8:0]           p_top;
    logic [FREQ_W-1:0]    shadow_freq;
    logic [1:0]           shadow_wave;
    logic [1:0]           active_wave;
    logic [MAG_W-1:0]     sin_lat;
    logic [MAG_W-1:0]     cos_lat;
    logic [CNT_W-1:0]     wait_cnt;
    logic [7:0]           shaped;
    logic [7:0]           shape_val;
    logic [7:0]           trig_val;
    logic [MAG_W-1:0]     mag;
    logic                 neg;
    logic [1:0]           quad;
    logic                 accept;
    logic                 wait_hit;
    logic                 timed_out;

    assign accept       = tick && en && (state == IDLE);
    assign wait_hit     = (wait_cnt == CNT_W'(TIMEOUT - 1));
    assign timed_out    = (state == WAIT) && !cordic_done && wait_hit;
    assign cordic_start = (state == ISSUE);
    assign busy         = (state != IDLE);
    assign quad         = p_top[8:7];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // The shadow wave decides the path because it becomes the active wave on this same edge.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (tick && en) state_next = shadow_wave[1] ? SHAPE : ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT: begin
                if (cordic_done)   state_next = SHAPE;
                else if (wait_hit) state_next = OUT;
            end
            SHAPE:   state_next = OUT;
            OUT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Only the top 9 phase bits are needed for shaping; the angle goes straight to the core.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase        <= '0;
            p_top        <= '0;
            shadow_freq  <= '0;
            shadow_wave  <= 2'b00;
            active_wave  <= 2'b00;
            cordic_angle <= '0;
        end else begin
            if (cfg_load) begin
                shadow_freq <= freq_word;
                shadow_wave <= wave_sel;
            end
            if (accept) begin
                active_wave <= shadow_wave;
                p_top       <= phase[PHASE_W-1 -: 9];
                phase       <= phase + PHASE_W'(shadow_freq);
                if (!shadow_wave[1]) cordic_angle <= phase[PHASE_W-3:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            sin_lat  <= '0;
            cos_lat  <= '0;
        end else begin
            if (state == ISSUE)     wait_cnt <= '0;
            else if (state == WAIT) wait_cnt <= wait_cnt + CNT_W'(1);
            if (state == WAIT && cordic_done) begin
                sin_lat <= cordic_sin;
                cos_lat <= cordic_cos;
            end
        end
    end

    // Sine and cosine share one quadrant table: cosine is sine advanced by one quadrant.
    always_comb begin
        mag = quad[0] ? cos_lat : sin_lat;
        neg = quad[1];
        if (active_wave[0]) begin
            mag = quad[0] ? sin_lat : cos_lat;
            neg = quad[0] ^ quad[1];
        end
        trig_val = neg ? (8'd128 - 8'(mag)) : (8'd128 + 8'(mag));
        case (active_wave)
            2'b10:   shape_val = p_top[8] ? ~p_top[7:0] : p_top[7:0];
            2'b11:   shape_val = p_top[8:1];
            default: shape_val = trig_val;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shaped       <= 8'h80;
            sample       <= 8'h80;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            if (state == SHAPE) shaped <= shape_val;
            else if (timed_out) shaped <= 8'h80;
            if (timed_out) timeout_err <= 1'b1;
            if (tick && en && (state != IDLE)) overrun <= 1'b1;
            sample_valid <= (state == OUT);
            if (state == OUT) sample <= shaped;
        end
    end

endmodule

// File: tb/tb_cordic_wave_sequencer.sv
// Directed bench for cordic_wave_sequencer: a transaction-level model predicts every output
// each cycle, and a behavioural CORDIC stand-in answers start pulses after a chosen latency.
module tb_cordic_wave_sequencer;

    localparam int TIMEOUT = 64;
    localparam int NEVER   = 32'h3fffffff;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        tick;
    logic        cfg_load;
    logic [12:0] freq_word;
    logic [1:0]  wave_sel;
    logic        cordic_start;
    logic [13:0] cordic_angle;
    logic        cordic_done;
    logic        core_done = 1'b0;
    logic        manual_done;
    logic [6:0]  cordic_sin = '0;
    logic [6:0]  cordic_cos = '0;
    logic [7:0]  sample;
    logic        sample_valid;
    logic        busy;
    logic        overrun;
    logic        timeout_err;

    assign cordic_done = core_done | manual_done;

    cordic_wave_sequencer dut (
        .clk(clk), .rst(rst), .en(en), .tick(tick), .cfg_load(cfg_load),
        .freq_word(freq_word), .wave_sel(wave_sel),
        .cordic_start(cordic_start), .cordic_angle(cordic_angle),
        .cordic_done(cordic_done), .cordic_sin(cordic_sin), .cordic_cos(cordic_cos),
        .sample(sample), .sample_valid(sample_valid), .busy(busy),
        .overrun(overrun), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;
    bit finished = 1'b0;

    // Model: phase/config registers plus at most one outstanding transaction.
    int m_phase, m_sh_freq, m_sh_wave, m_act_freq, m_act_wave;
    bit has_txn, t_trig;
    int t_tick, t_valid, t_value, t_angle;
    int prev_sample, prev_angle, ovr_from, tmo_from;
    int core_lat = 2;
    bit core_silent = 1'b0;

    function automatic int core_sin_of(input int a);
        return (a >> 7) & 127;
    endfunction

    function automatic int model_sample(input int p, input int wave);
        int q, s, c, m;
        q = (p >> 14) & 3;
        s = core_sin_of(p & 16383);
        c = 127 - s;
        m = 0;
        case (wave)
            0: m = (q == 0) ? s : (q == 1) ? c : (q == 2) ? -s : -c;
            1: m = (q == 0) ? c : (q == 1) ? -s : (q == 2) ? -c : s;
            2: return (p >= 32768) ? 255 - ((p >> 7) & 255) : ((p >> 7) & 255);
            default: return p >> 8;
        endcase
        return 128 + m;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, actual, expected);
        end
    endtask

    task automatic modelReset();
        m_phase = 0; m_sh_freq = 0; m_sh_wave = 0; m_act_freq = 0; m_act_wave = 0;
        has_txn = 1'b0; t_trig = 1'b0; t_tick = 0; t_valid = 0; t_value = 128; t_angle = 0;
        prev_sample = 128; prev_angle = 0; ovr_from = NEVER; tmo_from = NEVER;
    endtask

    task automatic modelAccept();
        int p;
        if (has_txn) begin
            prev_sample = t_value;
            if (t_trig) prev_angle = t_angle;
        end
        m_act_freq = m_sh_freq;
        m_act_wave = m_sh_wave;
        p = m_phase;
        m_phase = (m_phase + m_act_freq) % 65536;
        has_txn = 1'b1;
        t_tick  = cyc;
        t_trig  = (m_act_wave < 2);
        t_angle = p % 16384;
        if (!t_trig) begin
            t_valid = cyc + 3;
            t_value = model_sample(p, m_act_wave);
        end else if (core_silent || core_lat > TIMEOUT) begin
            t_valid = cyc + TIMEOUT + 3;
            t_value = 128;
            if (tmo_from == NEVER) tmo_from = cyc + TIMEOUT + 2;
        end else begin
            t_valid = cyc + 4 + core_lat;
            t_value = model_sample(p, m_act_wave);
        end
    endtask

    task automatic applyStimulus(input bit t, input bit load, input int f, input int w);
        @(posedge clk);
        #1;
        tick = t; cfg_load = load; freq_word = 13'(f); wave_sel = 2'(w);
        if (t && en) begin
            if (has_txn && cyc < t_valid) begin
                if (ovr_from == NEVER) ovr_from = cyc + 1;
            end else begin
                modelAccept();
            end
        end
        if (load) begin
            m_sh_freq = f;
            m_sh_wave = w;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, int'(freq_word), int'(wave_sel));
    endtask

    task automatic waitValid(output int vcyc, output int starts);
        vcyc = -1;
        starts = 0;
        for (int i = 0; i < 200; i++) begin
            applyStimulus(1'b0, 1'b0, int'(freq_word), int'(wave_sel));
            if (cordic_start) starts++;
            if (sample_valid) begin
                vcyc = cyc;
                break;
            end
        end
        if (vcyc < 0) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL wait_valid at cycle %0d: got no sample_valid, expected one within 200 cycles", cyc);
        end
    endtask

    task automatic tickAndCheck(input string name, input int f, input int w,
                                input int exp_sample, input int exp_lat, input int exp_starts);
        int tc, vc, starts;
        applyStimulus(1'b0, 1'b1, f, w);
        applyStimulus(1'b1, 1'b0, f, w);
        tc = cyc;
        waitValid(vc, starts);
        checkOutput({name, "_sample"}, int'(sample), exp_sample);
        checkOutput({name, "_latency"}, vc - tc, exp_lat);
        checkOutput({name, "_starts"}, starts, exp_starts);
    endtask

    // Core stand-in: |sin| = angle[13:7], |cos| = 127 - |sin|.
    initial begin
        int a;
        forever begin
            @(negedge clk);
            if (cordic_start === 1'b1 && !core_silent) begin
                a = int'(cordic_angle);
                repeat (core_lat) @(posedge clk);
                #1;
                core_done  = 1'b1;
                cordic_sin = 7'(core_sin_of(a));
                cordic_cos = 7'(127 - core_sin_of(a));
                @(posedge clk);
                #1;
                core_done = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!finished) begin
            checkOutput("sample_valid", int'(sample_valid), int'(has_txn && cyc == t_valid));
            checkOutput("busy", int'(busy), int'(has_txn && cyc > t_tick && cyc < t_valid));
            checkOutput("cordic_start", int'(cordic_start), int'(has_txn && t_trig && cyc == t_tick + 1));
            checkOutput("sample", int'(sample), (has_txn && cyc >= t_valid) ? t_value : prev_sample);
            checkOutput("cordic_angle", int'(cordic_angle),
                        (has_txn && t_trig && cyc > t_tick) ? t_angle : prev_angle);
            checkOutput("overrun", int'(overrun), int'(cyc >= ovr_from));
            checkOutput("timeout_err", int'(timeout_err), int'(cyc >= tmo_from));
        end
    end

    initial begin
        int lit_k [5] = '{0, 1, 4, 8, 12};
        int lit_v [5] = '{'h80, 'hA0, 'hFF, 'h80, 'h01};
        int vc, starts, tc, valids;

        rst = 1'b1; en = 1'b1; tick = 1'b0; cfg_load = 1'b0;
        freq_word = '0; wave_sel = '0; manual_done = 1'b0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_sample", int'(sample), 'h80);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_valid", int'(sample_valid), 0);
        checkOutput("reset_flags", int'({overrun, timeout_err}), 0);
        rst = 1'b0;
        idle(2);

        // Sine across all four quadrants.
        applyStimulus(1'b0, 1'b1, 'h1000, 0);
        for (int k = 0; k < 13; k++) begin
            applyStimulus(1'b1, 1'b0, 'h1000, 0);
            tc = cyc;
            waitValid(vc, starts);
            checkOutput("sine_angle", int'(cordic_angle), (k * 'h1000) & 'h3fff);
            checkOutput("sine_latency", vc - tc, 6);
            for (int j = 0; j < 5; j++)
                if (lit_k[j] == k) checkOutput("sine_quadrant", int'(sample), lit_v[j]);
        end

        // Reset in the middle of WAIT, then a stray done pulse.
        core_silent = 1'b1;
        applyStimulus(1'b1, 1'b0, 'h1000, 0);
        idle(5);
        @(posedge clk);
        #1;
        rst = 1'b1;
        modelReset();
        #1;
        checkOutput("rst_mid_sample", int'(sample), 'h80);
        checkOutput("rst_mid_busy", int'(busy), 0);
        checkOutput("rst_mid_start", int'(cordic_start), 0);
        idle(2);
        rst = 1'b0;
        idle(1);
        applyStimulus(1'b0, 1'b0, 0, 0);
        manual_done = 1'b1;
        valids = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b0, 0, 0);
            manual_done = 1'b0;
            if (sample_valid) valids++;
        end
        checkOutput("stray_done_valids", valids, 0);
        core_silent = 1'b0;

        // Tick with en low is ignored without raising a flag.
        en = 1'b0;
        applyStimulus(1'b1, 1'b0, 0, 0);
        applyStimulus(1'b0, 1'b0, 0, 0);
        en = 1'b1;
        idle(2);
        checkOutput("en_low_overrun", int'(overrun), 0);

        tickAndCheck("cos_p0000", 'h1800, 1, 'hFF, 6, 1);
        tickAndCheck("saw_p1800", 'h1800, 3, 'h18, 3, 0);
        tickAndCheck("saw_p3000", 'h0400, 3, 'h30, 3, 0);
        tickAndCheck("saw_p3400", 'h0400, 3, 'h34, 3, 0);
        applyStimulus(1'b0, 1'b1, 'h1100, 2);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1, 1'b0, 'h1100, 2);
            waitValid(vc, starts);
        end
        tickAndCheck("tri_pC000", 'h1100, 2, 'h7F, 3, 0);

        // Walk the phase to 0xFFFF and wrap it.
        tickAndCheck("tri_pD100", 'h1FFF, 2, 'h5D, 3, 0);
        tickAndCheck("tri_pF0FF", 'h0F00, 2, 'h1E, 3, 0);
        tickAndCheck("tri_pFFFF", 'h1FFF, 2, 'h00, 3, 0);
        tickAndCheck("wrap_sine", 'h0100, 0, 'hBF, 6, 1);
        checkOutput("wrap_angle", int'(cordic_angle), 'h1FFE);

        // Reconfigure and tick while the core is still working.
        core_lat = 10;
        applyStimulus(1'b1, 1'b0, 'h0100, 0);
        tc = cyc;
        idle(3);
        applyStimulus(1'b0, 1'b1, 'h0100, 2);
        applyStimulus(1'b1, 1'b0, 'h0100, 2);
        waitValid(vc, starts);
        checkOutput("cfg_mid_sine", int'(sample), 'hC1);
        checkOutput("cfg_mid_latency", vc - tc, 14);
        checkOutput("overrun_set", int'(overrun), 1);
        applyStimulus(1'b1, 1'b0, 'h0100, 2);
        tc = cyc;
        waitValid(vc, starts);
        checkOutput("cfg_next_tri", int'(sample), 'h43);
        checkOutput("cfg_next_latency", vc - tc, 3);

        // Done on the last allowed WAIT cycle wins over the timeout.
        core_lat = TIMEOUT;
        tickAndCheck("done_at_limit", 'h0100, 0, 'hC5, 68, 1);
        checkOutput("done_at_limit_tmo", int'(timeout_err), 0);

        core_silent = 1'b1;
        tickAndCheck("timeout", 'h0100, 0, 'h80, 67, 1);
        checkOutput("timeout_flag", int'(timeout_err), 1);

        idle(3);
        finished = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
